hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_perf_cnt.sv | 32 +++
 rtl/hazard_control_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared FSM state type, constants and the load-use predicate
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int HZ_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        DMEM_WAIT  = 2'd2
    } hz_state_t;

    // Store data (rs2) is forwarded at MEM, so only a store's address operand can be hurt by a load.
    function automatic logic is_load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd,
        input logic       uses_rs1,
        input logic       uses_rs2,
        input logic       is_store,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) ||
                (uses_rs2 && (rs2 == rd) && !is_store));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
// hazard_perf_cnt : free-running stall / flush performance counters (mod 2^32)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module hazard_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        flush_any,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (stall_if) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_any) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit : pipeline stall/flush control (dmem wait > redirect >
//                       load-use > imem wait). Optional: HAZARD_PERF_CNT_EN.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        uses_rs1_id,
    input  logic        uses_rs2_id,
    input  logic        is_store_id,
    input  logic [4:0]  rd_exe,
    input  logic        mem_read_exe,
    input  logic        branch_taken_exe,
    input  logic        dmem_req_mem,
    input  logic        dmem_ack,
    input  logic        imem_ack,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_exe,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_exe,
    output logic        flush_wb,
    output logic        bus_error,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [HZ_TIMEOUT_W:0] TIMEOUT_LIMIT = DMEM_TIMEOUT[HZ_TIMEOUT_W:0];

    hz_state_t               state;
    logic [HZ_TIMEOUT_W-1:0] wait_cnt;
    logic [HZ_TIMEOUT_W:0]   cnt_next;
    logic                    in_wait;
    logic                    load_use;
    logic                    load_use_active;
    logic                    timeout;
    logic                    dmem_stall;

    always_comb begin
        in_wait         = (state == DMEM_WAIT);
        load_use        = is_load_use(rs1_id, rs2_id, rd_exe, uses_rs1_id, uses_rs2_id,
                                      is_store_id, mem_read_exe);
        // LOAD_STALL ignores the condition: the load has already moved on to MEM.
        load_use_active = load_use && (state != LOAD_STALL);
        // wait_cnt counts completed DMEM_WAIT cycles; cnt_next includes the current one.
        cnt_next        = {1'b0, wait_cnt} + {{HZ_TIMEOUT_W{1'b0}}, 1'b1};
        timeout         = in_wait && !dmem_ack && (cnt_next == TIMEOUT_LIMIT);
        dmem_stall      = in_wait ? (!dmem_ack && !timeout) : (dmem_req_mem && !dmem_ack);
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_exe = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_exe = 1'b0;
        flush_wb  = 1'b0;
        bus_error = 1'b0;
        if (!reset) begin
            bus_error = timeout;
            if (dmem_stall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_exe = 1'b1;
                stall_mem = 1'b1;
                flush_wb  = 1'b1;
            end else if (branch_taken_exe) begin
                flush_id  = 1'b1;
                flush_exe = 1'b1;
            end else if (load_use_active) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_exe = 1'b1;
            end else if (!imem_ack) begin
                stall_if  = 1'b1;
                flush_id  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else if (dmem_stall) begin
            state    <= DMEM_WAIT;
            wait_cnt <= in_wait ? cnt_next[HZ_TIMEOUT_W-1:0] : '0;
        end else if (load_use_active && !branch_taken_exe) begin
            state    <= LOAD_STALL;
        end else begin
            state    <= RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .stall_if     (stall_if),
        .flush_any    (flush_id | flush_exe),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

`default_nettype wire
